// File: rtl/tx_block.sv
`default_nettype none
// ============================================================================
// Module      : tx_block
// Description : UART transmitter for the APB UART peripheral. Sends frames of
//               start(0), 5..8 data bits LSB-first, optional even parity and
//               stop(1). A one-entry holding buffer in front of the shifter
//               allows back-to-back frames with no idle gap.
//               Optional feature macro: TX_PARITY_EN (adds the parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tx_block (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  data_size,
    input  logic [13:0] bit_period,
    input  logic [7:0]  tx_data,
    input  logic        data_write,
    input  logic        err_clear,
    output logic        serial_out,
    output logic        tx_busy,
    output logic        tx_buf_full,
    output logic        overrun_error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [13:0] r_timer;
    logic [13:0] r_period;
    logic [3:0]  r_size;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_buf;
    logic        r_buf_full;
    logic        r_ovr;
    logic        r_serial;
    logic        r_busy;
`ifdef TX_PARITY_EN
    logic        r_parity;
    logic [7:0]  w_mask;
`endif

    logic [3:0]  w_size;
    logic [13:0] w_period;
    logic        w_wrap;
    logic        w_xfer;
    logic        w_accept;
    logic        w_overrun;

    // Clamp live configuration, detect bit boundaries and buffer hand-off
    always_comb begin
        w_size    = ((data_size >= 4'd5) && (data_size <= 4'd8)) ? data_size : 4'd8;
        w_period  = (bit_period < 14'd2) ? 14'd2 : bit_period;
`ifdef TX_PARITY_EN
        case (w_size)
            4'd5:    w_mask = 8'h1F;
            4'd6:    w_mask = 8'h3F;
            4'd7:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
`endif
        w_wrap    = (r_timer == (r_period - 14'd1));
        // Buffer moves to the shifter from IDLE, or at the end of a stop bit
        w_xfer    = r_buf_full && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_STOP) && w_wrap));
        // A write landing on the hand-off edge refills the freed slot
        w_accept  = data_write && (!r_buf_full || w_xfer);
        w_overrun = data_write && r_buf_full && !w_xfer;
    end

    // Holding buffer and sticky overrun flag (a new overrun beats err_clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= 8'h00;
            r_buf_full <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_xfer) begin
                r_buf_full <= 1'b0;
            end
            if (w_overrun) begin
                r_ovr <= 1'b1;
            end else if (err_clear) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Frame sequencer; line and busy are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= 14'd0;
            r_period  <= 14'd2;
            r_size    <= 4'd8;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
`ifdef TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_xfer) begin
            // Configuration is frozen here for the whole frame
            r_state   <= ST_START;
            r_timer   <= 14'd0;
            r_period  <= w_period;
            r_size    <= w_size;
            r_bit_cnt <= 4'd0;
            r_shift   <= r_buf;
            r_serial  <= 1'b0;
            r_busy    <= 1'b1;
`ifdef TX_PARITY_EN
            r_parity  <= ^(r_buf & w_mask);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timer  <= 14'd0;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
                ST_START: begin
                    if (w_wrap) begin
                        r_timer  <= 14'd0;
                        r_state  <= ST_DATA;
                        r_serial <= r_shift[0];
                    end else begin
                        r_timer <= r_timer + 14'd1;
                    end
                end
                ST_DATA: begin
                    if (w_wrap) begin
                        r_timer <= 14'd0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == (r_size - 4'd1)) begin
                            r_bit_cnt <= 4'd0;
`ifdef TX_PARITY_EN
                            r_state   <= ST_PARITY;
                            r_serial  <= r_parity;
`else
                            r_state   <= ST_STOP;
                            r_serial  <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + 14'd1;
                    end
                end
`ifdef TX_PARITY_EN
                ST_PARITY: begin
                    if (w_wrap) begin
                        r_timer  <= 14'd0;
                        r_state  <= ST_STOP;
                        r_serial <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 14'd1;
                    end
                end
`endif
                ST_STOP: begin
                    // A full buffer at wrap is taken by the hand-off branch above
                    if (w_wrap) begin
                        r_timer  <= 14'd0;
                        r_state  <= ST_IDLE;
                        r_serial <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 14'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_timer  <= 14'd0;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign serial_out    = r_serial;
    assign tx_busy       = r_busy;
    assign tx_buf_full   = r_buf_full;
    assign overrun_error = r_ovr;

endmodule
`default_nettype wire
